// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request handshakes from both writeback sources plus the register-file write port.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              A_Valid;
    logic              A_Ready;
    logic [ADDR_W-1:0] A_Addr;
    logic [DATA_W-1:0] A_Data;
    logic              B_Valid;
    logic              B_Ready;
    logic [ADDR_W-1:0] B_Addr;
    logic [DATA_W-1:0] B_Data;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              GrantB;
    logic              Idle;

    modport master (
        output A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data,
        input  A_Ready, B_Ready, RegWrite, WriteRegister, WriteData, GrantB, Idle
    );

    modport slave (
        input  A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data,
        output A_Ready, B_Ready, RegWrite, WriteRegister, WriteData, GrantB, Idle
    );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding queued writebacks for one source.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the wrap
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port between ALU (A) and load (B) writeback.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic               a_push, a_pop, a_empty, a_full;
    logic               b_push, b_pop, b_empty, b_full;
    logic [ENTRY_W-1:0] a_dout, b_dout, head;

    logic               pop_any, tie;
    src_e               sel;
    src_e               last_grant_q, last_grant_d;
    src_e               grant_q, grant_d;
    logic               reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    // R0 writes complete the handshake but are never queued
    assign a_push = bus.A_Valid & ~a_full & (bus.A_Addr != ADDR_W'(REG_ZERO));
    assign b_push = bus.B_Valid & ~b_full & (bus.B_Addr != ADDR_W'(REG_ZERO));

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo_a (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (a_push),
        .pop   (a_pop),
        .din   ({bus.A_Addr, bus.A_Data}),
        .dout  (a_dout),
        .empty (a_empty),
        .full  (a_full)
    );

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo_b (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (b_push),
        .pop   (b_pop),
        .din   ({bus.B_Addr, bus.B_Data}),
        .dout  (b_dout),
        .empty (b_empty),
        .full  (b_full)
    );

    always_comb begin
        pop_any      = ~a_empty | ~b_empty;
        tie          = ~a_empty & ~b_empty;
        sel          = SRC_A;
        last_grant_d = last_grant_q;
        // last_grant only moves when both sources actually contended
        if (tie) begin
            sel          = (last_grant_q == SRC_A) ? SRC_B : SRC_A;
            last_grant_d = sel;
        end else if (~b_empty) begin
            sel = SRC_B;
        end
        a_pop = pop_any & (sel == SRC_A);
        b_pop = pop_any & (sel == SRC_B);
        head  = (sel == SRC_B) ? b_dout : a_dout;

        reg_write_d = pop_any;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        grant_d     = grant_q;
        if (pop_any) begin
            waddr_d = head[ENTRY_W-1 -: ADDR_W];
            wdata_d = head[DATA_W-1:0];
            grant_d = sel;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            reg_write_q  <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            grant_q      <= SRC_A;
            last_grant_q <= SRC_B;
        end else begin
            reg_write_q  <= reg_write_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.A_Ready       = ~a_full;
    assign bus.B_Ready       = ~b_full;
    assign bus.RegWrite      = reg_write_q;
    assign bus.WriteRegister = waddr_q;
    assign bus.WriteData     = wdata_q;
    assign bus.GrantB        = (grant_q == SRC_B);
    assign bus.Idle          = a_empty & b_empty & ~reg_write_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a queue-based reference model.
module tb_regfile_write_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct packed {
        logic [31:0]       cyc;
        logic              g;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic Clk, Rst;
    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit exceeded");
        $fatal(1);
    end

    // Reference model: one queue per source, pops decided on pre-edge occupancy
    ent_t              mqa[$], mqb[$];
    logic              m_last, m_rw, m_grant;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    bit                model_on = 0;

    always @(posedge Clk) begin : model
        ent_t e;
        logic src, a_ok, b_ok;
        if (Rst) begin
            mqa.delete();
            mqb.delete();
            m_last   = 1'b1;
            m_rw     = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_grant  = 1'b0;
            model_on = 1;
        end else begin
            a_ok = bus.A_Valid && (mqa.size() < DEPTH);
            b_ok = bus.B_Valid && (mqb.size() < DEPTH);
            src  = 1'b0;
            if (mqa.size() != 0 && mqb.size() != 0) begin
                src    = ~m_last;
                m_last = src;
            end else if (mqb.size() != 0) begin
                src = 1'b1;
            end
            if (mqa.size() != 0 || mqb.size() != 0) begin
                e       = src ? mqb.pop_front() : mqa.pop_front();
                m_rw    = 1'b1;
                m_addr  = e.addr;
                m_data  = e.data;
                m_grant = src;
            end else begin
                m_rw = 1'b0;
            end
            if (a_ok && bus.A_Addr != 0) mqa.push_back('{bus.A_Addr, bus.A_Data});
            if (b_ok && bus.B_Addr != 0) mqb.push_back('{bus.B_Addr, bus.B_Data});
        end
    end

    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, stall_a = 0, stall_b = 0;
    wr_t  wlog[$];
    ent_t pend_a[$], pend_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        cyc++;
        if (bus.RegWrite) wlog.push_back('{32'(cyc), bus.GrantB, bus.WriteRegister, bus.WriteData});
        if (model_on) begin
            check("m_regwrite", bus.RegWrite, m_rw);
            check("m_grantb",   bus.GrantB, m_grant);
            check("m_waddr",    bus.WriteRegister, m_addr);
            check("m_wdata",    bus.WriteData, m_data);
            check("m_idle",     bus.Idle, (mqa.size() == 0 && mqb.size() == 0 && !m_rw));
            check("m_a_ready",  bus.A_Ready, (mqa.size() < DEPTH));
            check("m_b_ready",  bus.B_Ready, (mqb.size() < DEPTH));
        end
    endtask

    task automatic run_pending(input int budget);
        int   n = 0;
        logic ra, rb;
        while ((pend_a.size() != 0 || pend_b.size() != 0) && n < budget) begin
            ra = bus.A_Ready;
            rb = bus.B_Ready;
            if (pend_a.size() != 0) begin
                bus.A_Valid = 1'b1;
                bus.A_Addr  = pend_a[0].addr;
                bus.A_Data  = pend_a[0].data;
                if (!ra) stall_a++;
            end else bus.A_Valid = 1'b0;
            if (pend_b.size() != 0) begin
                bus.B_Valid = 1'b1;
                bus.B_Addr  = pend_b[0].addr;
                bus.B_Data  = pend_b[0].data;
                if (!rb) stall_b++;
            end else bus.B_Valid = 1'b0;
            tick();
            if (bus.A_Valid && ra) pend_a.delete(0);
            if (bus.B_Valid && rb) pend_b.delete(0);
            n++;
        end
        bus.A_Valid = 1'b0;
        bus.B_Valid = 1'b0;
        check("handshake_timeout", pend_a.size() + pend_b.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!bus.Idle && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", bus.Idle, 1);
    endtask

    task automatic expect_write(input string nm, input int idx, input logic g,
                                input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (idx < wlog.size()) begin
            check({nm, "_grant"}, wlog[idx].g, g);
            check({nm, "_addr"},  wlog[idx].addr, a);
            check({nm, "_data"},  wlog[idx].data, d);
        end else begin
            check({nm, "_count"}, wlog.size(), idx + 1);
        end
    endtask

    initial begin : stim
        int s, sa, sb;
        Rst = 1'b1;
        bus.A_Valid = 1'b0; bus.A_Addr = '0; bus.A_Data = '0;
        bus.B_Valid = 1'b0; bus.B_Addr = '0; bus.B_Data = '0;
        tick();
        tick();
        Rst = 1'b0;

        check("rst_regwrite", bus.RegWrite, 0);
        check("rst_waddr",    bus.WriteRegister, 0);
        check("rst_wdata",    bus.WriteData, 0);
        check("rst_grantb",   bus.GrantB, 0);
        check("rst_idle",     bus.Idle, 1);
        check("rst_a_ready",  bus.A_Ready, 1);
        check("rst_b_ready",  bus.B_Ready, 1);

        // Single write: push at edge 1, write strobe during cycle 2 only
        pend_a.push_back('{5'd3, 32'h1234_5678});
        run_pending(10);
        check("single_c1_regwrite", bus.RegWrite, 0);
        check("single_c1_idle",     bus.Idle, 0);
        tick();
        check("single_c2_regwrite", bus.RegWrite, 1);
        check("single_c2_waddr",    bus.WriteRegister, 3);
        check("single_c2_wdata",    bus.WriteData, 32'h1234_5678);
        check("single_c2_grantb",   bus.GrantB, 0);
        tick();
        check("single_c3_regwrite", bus.RegWrite, 0);
        check("single_c3_idle",     bus.Idle, 1);

        // Tie fairness
        s = wlog.size();
        pend_a.push_back('{5'd4, 32'hA1}); pend_a.push_back('{5'd5, 32'hA2});
        pend_b.push_back('{5'd6, 32'hB1}); pend_b.push_back('{5'd7, 32'hB2});
        run_pending(20);
        wait_idle(20);
        check("tie_count", wlog.size() - s, 4);
        expect_write("tie0", s,     1'b0, 5'd4, 32'hA1);
        expect_write("tie1", s + 1, 1'b1, 5'd6, 32'hB1);
        expect_write("tie2", s + 2, 1'b0, 5'd5, 32'hA2);
        expect_write("tie3", s + 3, 1'b1, 5'd7, 32'hB2);

        // Back-pressure on B while A competes (fresh last_grant)
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        s = wlog.size(); sa = stall_a; sb = stall_b;
        for (int unsigned i = 0; i < 3; i++) begin
            pend_a.push_back('{5'(11 + i), 32'hA000_0000 + i});
            pend_b.push_back('{5'(8 + i),  32'hB000_0000 + i});
        end
        run_pending(20);
        wait_idle(20);
        check("bp_b_stalls", stall_b - sb, 1);
        check("bp_a_stalls", stall_a - sa, 0);
        check("bp_count", wlog.size() - s, 6);
        expect_write("bp0", s,     1'b0, 5'd11, 32'hA000_0000);
        expect_write("bp1", s + 1, 1'b1, 5'd8,  32'hB000_0000);
        expect_write("bp2", s + 2, 1'b0, 5'd12, 32'hA000_0001);
        expect_write("bp3", s + 3, 1'b1, 5'd9,  32'hB000_0001);
        expect_write("bp4", s + 4, 1'b0, 5'd13, 32'hA000_0002);
        expect_write("bp5", s + 5, 1'b1, 5'd10, 32'hB000_0002);

        // R0 suppression
        s = wlog.size();
        pend_a.push_back('{5'd0, 32'hDEAD_BEEF});
        run_pending(5);
        for (int i = 0; i < 3; i++) begin
            check("r0_regwrite", bus.RegWrite, 0);
            check("r0_idle",     bus.Idle, 1);
            tick();
        end
        check("r0_count", wlog.size() - s, 0);

        // Reset mid-stream
        bus.A_Valid = 1'b1; bus.A_Addr = 5'd20; bus.A_Data = 32'hAAAA_0000;
        bus.B_Valid = 1'b1; bus.B_Addr = 5'd21; bus.B_Data = 32'hBBBB_0000;
        for (int i = 0; i < 3; i++) tick();
        check("mid_busy", bus.Idle, 0);
        bus.A_Valid = 1'b0;
        bus.B_Valid = 1'b0;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        s = wlog.size();
        check("mid_rst_regwrite", bus.RegWrite, 0);
        check("mid_rst_idle",     bus.Idle, 1);
        check("mid_rst_a_ready",  bus.A_Ready, 1);
        check("mid_rst_b_ready",  bus.B_Ready, 1);
        check("mid_rst_waddr",    bus.WriteRegister, 0);
        for (int i = 0; i < 3; i++) tick();
        check("mid_no_writes", wlog.size() - s, 0);
        pend_a.push_back('{5'd1, 32'h111});
        pend_b.push_back('{5'd2, 32'h222});
        run_pending(10);
        wait_idle(10);
        expect_write("mid_tie0", s,     1'b0, 5'd1, 32'h111);
        expect_write("mid_tie1", s + 1, 1'b1, 5'd2, 32'h222);

        // Sustained A stream
        s = wlog.size(); sa = stall_a;
        for (int unsigned i = 0; i < 20; i++)
            pend_a.push_back('{5'((i % 31) + 1), 32'hC000_0000 + i});
        run_pending(40);
        wait_idle(10);
        check("sus_count", wlog.size() - s, 20);
        check("sus_a_stalls", stall_a - sa, 0);
        for (int i = 0; i < 20; i++) begin
            expect_write("sus", s + i, 1'b0, 5'((i % 31) + 1), 32'hC000_0000 + i);
            if (s + i < wlog.size())
                check("sus_consecutive", wlog[s + i].cyc - wlog[s].cyc, i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
